// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: stage-1 pixel request 1 clk after the counter, pins 2+PIPE_LAT clks after it.
// No backpressure: runs every pixel clock; en only parks the raster at the origin.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12,
  parameter int COLOR_W  = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic               char_clock,
  input  logic               reset_n,
  input  logic               en,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic [CW-1:0]      pix_x,
  output logic [CW-1:0]      pix_y,
  output logic               pix_req,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW1     = CW + 1;

  // One extra bit so a region end equal to 2^CW still compares correctly.
  localparam logic [CW:0] H_ACT_END  = CW1'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END  = CW1'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = CW1'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_act;
  logic          v_act;
  logic          hs_act;
  logic          vs_act;
  logic          vis;
  sync_t         raw;
  sync_t         dly [PIPE_LAT+1];

  always_comb begin
    h_act  = {1'b0, h_cnt} < H_ACT_END;
    v_act  = {1'b0, v_cnt} < V_ACT_END;
    hs_act = ({1'b0, h_cnt} >= H_SYNC_BEG) && ({1'b0, h_cnt} < H_SYNC_END);
    vs_act = ({1'b0, v_cnt} >= V_SYNC_BEG) && ({1'b0, v_cnt} < V_SYNC_END);
    vis    = h_act && v_act;
    // A parked raster feeds idle values into the delay line.
    raw.hs = en && hs_act;
    raw.vs = en && vs_act;
    raw.de = en && vis;
  end

  always_ff @(posedge char_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge char_clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_req     <= vis;
      pix_x       <= vis ? h_cnt : '0;
      pix_y       <= v_act ? v_cnt : '0;
      line_start  <= vis && (h_cnt == '0);
      frame_start <= vis && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // dly[PIPE_LAT] lines up with the rgb_in returned for the same pixel.
  always_ff @(posedge char_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= PIPE_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= raw;
      for (int i = 1; i <= PIPE_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  always_ff @(posedge char_clock or negedge reset_n) begin
    if (!reset_n) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de    <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      hsync <= dly[PIPE_LAT].hs ? HS_POL : ~HS_POL;
      vsync <= dly[PIPE_LAT].vs ? VS_POL : ~VS_POL;
      de    <= dly[PIPE_LAT].de;
      red   <= dly[PIPE_LAT].de ? red_in   : '0;
      green <= dly[PIPE_LAT].de ? green_in : '0;
      blue  <= dly[PIPE_LAT].de ? blue_in  : '0;
    end
  end

endmodule
